freq_bcd_converter: RTL and testbench

Downstream stage of the frequency detector: snapshots the 32-bit binary `freq` word at a fixed refresh rate, or on request, and converts it to packed BCD for the display/UART layer. Conversion is sequential shift-add-3 (double dabble), one bit per clock. Results are registered and flagged with a one-cycle valid pulse. Values that do not fit in the digit count saturate and raise an overflow flag.

---
 rtl/freq_bcd_converter_pkg.sv | 24 ++
 rtl/freq_bcd_converter_if.sv | 25 ++
 rtl/freq_bcd_converter_bcd_add3_shift.sv | 26 ++
 rtl/freq_bcd_converter.sv | 124 ++++++++++++
 tb/tb_freq_bcd_converter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/freq_bcd_converter_pkg.sv
// Shared constants, FSM state type and helpers for the frequency-to-BCD path.
package freq_pkg;

    localparam int unsigned CLK_FREQ_HZ = 20000000;
    localparam int unsigned BCD_W       = 4;
    localparam int unsigned MAX_DIGITS  = 16;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // All-9s pattern in the low `digits` nibbles; callers slice to their width.
    function automatic logic [BCD_W*MAX_DIGITS-1:0] max_bcd(input int unsigned digits);
        logic [BCD_W*MAX_DIGITS-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) r[i*BCD_W +: BCD_W] = 4'h9;
        end
        return r;
    endfunction

endpackage

// File: rtl/freq_bcd_converter_if.sv
// Sample/result bundle between the frequency detector side and the display side.
interface freq_bcd_converter_if #(
    parameter int unsigned IN_W   = 32,
    parameter int unsigned DIGITS = 7
) ();

    logic [IN_W-1:0]     freq;
    logic                sample_req;
    logic [4*DIGITS-1:0] bcd;
    logic                bcd_valid;
    logic                overflow;
    logic [DIGITS-1:0]   blank;
    logic                busy;

    modport master (
        output freq, sample_req,
        input  bcd, bcd_valid, overflow, blank, busy
    );

    modport slave (
        input  freq, sample_req,
        output bcd, bcd_valid, overflow, blank, busy
    );

endinterface

// File: rtl/freq_bcd_converter_bcd_add3_shift.sv
// One combinational double-dabble step: add 3 to each nibble >= 5, then shift left.
module bcd_add3_shift
    import freq_pkg::*;
#(
    parameter int unsigned DIGITS = 7,
    parameter int unsigned IN_W   = 32
) (
    input  logic [BCD_W*DIGITS-1:0] acc_in,
    input  logic [IN_W-1:0]         sreg_in,
    output logic [BCD_W*DIGITS-1:0] acc_out,
    output logic [IN_W-1:0]         sreg_out,
    output logic                    carry
);

    logic [BCD_W*DIGITS-1:0] adj;

    always_comb begin
        adj = acc_in;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (acc_in[i*BCD_W +: BCD_W] >= 4'd5)
                adj[i*BCD_W +: BCD_W] = acc_in[i*BCD_W +: BCD_W] + 4'd3;
        end
        {carry, acc_out, sreg_out} = {adj, sreg_in, 1'b0};
    end

endmodule

// File: rtl/freq_bcd_converter.sv
// Periodic/on-demand binary-to-BCD converter with saturation.
// Optional leading-zero blank mask enabled by FREQ_BCD_BLANK_EN.
module freq_bcd_converter
    import freq_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = CLK_FREQ_HZ,
    parameter int unsigned REFRESH_HZ = 10,
    parameter int unsigned IN_W       = 32,
    parameter int unsigned DIGITS     = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    freq_bcd_converter_if.slave bus
);

    localparam int unsigned PERIOD = CLK_FREQ / REFRESH_HZ;
    localparam int unsigned TW     = $clog2(PERIOD);
    localparam int unsigned CW     = $clog2(IN_W + 1);
    localparam int unsigned AW     = BCD_W * DIGITS;
    localparam logic [BCD_W*MAX_DIGITS-1:0] SAT_ALL = max_bcd(DIGITS);
    localparam logic [AW-1:0] BCD_SAT = SAT_ALL[AW-1:0];

    state_t          state;
    logic [TW-1:0]   timer;
    logic            tick;
    logic            start;
    logic [IN_W-1:0] sreg, sreg_nxt;
    logic [AW-1:0]   acc, acc_nxt;
    logic            carry;
    logic            ovf;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   bcd_q;
    logic            ovf_q;
    logic            valid_q;

    assign tick  = (timer == TW'(PERIOD - 1));
    assign start = (tick | bus.sample_req) & (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timer <= '0;
        else        timer <= tick ? '0 : timer + TW'(1);
    end

    bcd_add3_shift #(
        .DIGITS (DIGITS),
        .IN_W   (IN_W)
    ) u_step (
        .acc_in   (acc),
        .sreg_in  (sreg),
        .acc_out  (acc_nxt),
        .sreg_out (sreg_nxt),
        .carry    (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sreg    <= '0;
            acc     <= '0;
            ovf     <= 1'b0;
            cnt     <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg  <= bus.freq;
                        acc   <= '0;
                        ovf   <= 1'b0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc  <= acc_nxt;
                    sreg <= sreg_nxt;
                    ovf  <= ovf | carry;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(IN_W - 1)) state <= DONE;
                end
                DONE: begin
                    bcd_q   <= ovf ? BCD_SAT : acc;
                    ovf_q   <= ovf;
                    valid_q <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.bcd       = bcd_q;
    assign bus.overflow  = ovf_q;
    assign bus.bcd_valid = valid_q;
    assign bus.busy      = (state != IDLE);

`ifdef FREQ_BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_nxt;

    // Walk from the top digit down; a digit blanks only while everything above is zero.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank_nxt  = '0;
        for (int unsigned k = 1; k < DIGITS; k++) begin
            zero_above = zero_above & (acc[(DIGITS-k)*BCD_W +: BCD_W] == 4'd0);
            blank_nxt[DIGITS-k] = zero_above;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
        else if (state == DONE)  blank_q <= ovf ? '0 : blank_nxt;
    end

    assign bus.blank = blank_q;
`else
    assign bus.blank = '0;
`endif

endmodule

// File: tb/tb_freq_bcd_converter.sv
// Self-checking bench for freq_bcd_converter against an arithmetic decimal model.
module tb_freq_bcd_converter;

    localparam int unsigned P      = 640;
    localparam int unsigned DIG    = 7;
    localparam int unsigned MAXVAL = 9999999;
`ifdef FREQ_BCD_BLANK_EN
    localparam logic [DIG-1:0] BLANK_RST = 7'b1111110;
`else
    localparam logic [DIG-1:0] BLANK_RST = 7'b0000000;
`endif

    logic        clk;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;
    int unsigned edges;
    int unsigned vcnt = 0;

    freq_bcd_converter_if #(.IN_W(32), .DIGITS(DIG)) bus ();

    freq_bcd_converter #(
        .CLK_FREQ   (6400),
        .REFRESH_HZ (10),
        .IN_W       (32),
        .DIGITS     (DIG)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    always @(posedge clk) begin
        #1;
        if (bus.bcd_valid === 1'b1) vcnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [27:0] ref_bcd(input logic [31:0] v);
        logic [27:0]     r;
        longint unsigned x;
        r = '0;
        x = v;
        if (x > MAXVAL) return 28'h9999999;
        for (int i = 0; i < 7; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [DIG-1:0] ref_blank(input logic [31:0] v);
        logic [DIG-1:0]  r;
        longint unsigned p;
        r = '0;
`ifdef FREQ_BCD_BLANK_EN
        p = 10;
        if (v <= MAXVAL) begin
            for (int i = 1; i < DIG; i++) begin
                r[i] = (longint'(v) < p);
                p = p * 10;
            end
        end
`else
        p = 0;
        if (v == 0) r = r + DIG'(p);
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] v);
        check({tag, "_bcd"}, 64'(bus.bcd), 64'(ref_bcd(v)));
        check({tag, "_ovf"}, 64'(bus.overflow), 64'(v > MAXVAL));
        check({tag, "_blank"}, 64'(bus.blank), 64'(ref_blank(v)));
    endtask

    task automatic wait_valid(input int unsigned budget, output int unsigned n);
        n = 0;
        while (n < budget && bus.bcd_valid !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        check("valid_seen", 64'(bus.bcd_valid), 64'd1);
    endtask

    task automatic do_conv(input logic [31:0] v, input string tag);
        int unsigned n;
        @(negedge clk);
        bus.freq       = v;
        bus.sample_req = 1'b1;
        @(negedge clk);
        bus.sample_req = 1'b0;
        n = 0;
        while (n < 60 && bus.bcd_valid !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n == 2)  bus.freq = $urandom;
            if (n == 10) check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        end
        check({tag, "_seen"}, 64'(bus.bcd_valid), 64'd1);
        check({tag, "_lat"}, 64'(n), 64'd33);
        check_result(tag, v);
        @(negedge clk);
        check({tag, "_pulse1"}, 64'(bus.bcd_valid), 64'd0);
        check({tag, "_idle"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bcd"}, 64'(bus.bcd), 64'd0);
        check({tag, "_ovf"}, 64'(bus.overflow), 64'd0);
        check({tag, "_valid"}, 64'(bus.bcd_valid), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_blank"}, 64'(bus.blank), 64'(BLANK_RST));
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] dir_vals [7];
        logic [31:0] v;
        int unsigned n;
        int unsigned g;
        int unsigned v0;

        dir_vals = '{32'd1234567, 32'd9999999, 32'd10000000, 32'd5,
                     32'hFFFF_FFFF, 32'd300000, 32'd1000000};

        rst_n          = 1'b0;
        bus.freq       = '0;
        bus.sample_req = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // On-demand conversions, all well before the first refresh tick.
        do_conv(32'd0, "zero");
        for (int i = 0; i < 7; i++) do_conv(dir_vals[i], $sformatf("dir%0d", i));
        for (int i = 0; i < 4; i++) begin
            v = (i % 2 == 0) ? $urandom_range(0, MAXVAL) : $urandom;
            do_conv(v, $sformatf("rnd%0d", i));
        end

        // First automatic conversion after a fresh reset.
        bus.freq = 32'd300000;
        reset_dut();
        wait_valid(P + 60, n);
        check("tick_start_edge", 64'(edges), 64'(P + 33));
        check_result("tick", 32'd300000);

        // sample_req coinciding with a tick, then a dropped request while busy.
        g = 0;
        while (edges != 2*P - 1 && g < P) begin
            @(negedge clk);
            g++;
        end
        v              = $urandom_range(1, MAXVAL);
        bus.freq       = v;
        bus.sample_req = 1'b1;
        v0             = vcnt;
        @(negedge clk);
        bus.sample_req = 1'b0;
        repeat (9) @(negedge clk);
        check("coinc_busy", 64'(bus.busy), 64'd1);
        bus.sample_req = 1'b1;
        @(negedge clk);
        bus.sample_req = 1'b0;
        wait_valid(60, n);
        check("coinc_edge", 64'(edges), 64'(2*P + 33));
        check_result("coinc", v);
        repeat (60) @(negedge clk);
        check("coinc_count", 64'(vcnt - v0), 64'd1);

        // Reset in the middle of a conversion.
        @(negedge clk);
        bus.freq       = $urandom_range(0, MAXVAL);
        bus.sample_req = 1'b1;
        @(negedge clk);
        bus.sample_req = 1'b0;
        v0             = vcnt;
        repeat (14) @(negedge clk);
        check("abort_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_novalid", 64'(vcnt - v0), 64'd0);
        do_conv($urandom_range(0, MAXVAL), "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
